// File: rtl/lc3_ctrl_pkg.sv
// Shared encodings for the LC-3 PC/fetch controller and the datapath blocks
// that decode its select outputs.
package lc3_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH1 = 4'd1,
    S_FETCH2 = 4'd2,
    S_FETCH3 = 4'd3,
    S_DECODE = 4'd4,
    S_BR     = 4'd5,
    S_JMP    = 4'd6,
    S_JSR    = 4'd7,
    S_EXEC   = 4'd8
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_RSV = 4'b1101;

  localparam logic [1:0] PCMUX_PC1 = 2'b00;
  localparam logic [1:0] PCMUX_BUS = 2'b01;
  localparam logic [1:0] PCMUX_EAB = 2'b10;

  localparam logic ADDR1_PC    = 1'b0;
  localparam logic ADDR1_BASER = 1'b1;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  // Control-flow opcodes get their own PC-update state; everything else,
  // including the reserved opcode, goes to the execute unit.
  function automatic state_t dispatch(input logic [3:0] opcode);
    case (opcode)
      OP_BR:   return S_BR;
      OP_JMP:  return S_JMP;
      OP_JSR:  return S_JSR;
      default: return S_EXEC;
    endcase
  endfunction

endpackage

// File: rtl/lc3_ben.sv
// Branch-enable evaluation: the BR instruction's n/z/p mask against the
// current condition codes.
module lc3_ben (
  input  logic [2:0] cond,
  input  logic [2:0] nzp,
  output logic       ben
);

  assign ben = |(cond & nzp);

endmodule

// File: rtl/lc3_pc_ctrl.sv
// LC-3 fetch/decode/PC-update sequencer. Moore outputs from registered state;
// only ldMDR looks at the memory handshake directly.
module lc3_pc_ctrl
  import lc3_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic [2:0]  nzp,
  input  logic        mem_r,
  input  logic        exec_done,
  output logic        ldMAR,
  output logic        gatePC,
  output logic        ldPC,
  output logic        mem_en,
  output logic        ldMDR,
  output logic        ldIR,
  output logic        ldR7,
  output logic        exec_start,
  output logic [1:0]  selPCMUX,
  output logic        selADDR1,
  output logic [1:0]  selADDR2,
  output logic [3:0]  state_dbg,
  output logic [15:0] icount
);

  state_t      state;
  state_t      state_nxt;
  logic        ben_now;
  logic        ben_q;
  logic        jsr_off11_q;
  logic        exec_first_q;
  logic        retire;
  logic [15:0] icount_q;
  logic        unused_ir;

  assign unused_ir = ^ir[8:0];

  lc3_ben u_ben (
    .cond (ir[11:9]),
    .nzp  (nzp),
    .ben  (ben_now)
  );

  // ben and the JSR addressing mode are captured in DECODE so the following
  // state's outputs depend on registered values only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      ben_q        <= 1'b0;
      jsr_off11_q  <= 1'b0;
      exec_first_q <= 1'b0;
      icount_q     <= '0;
    end else begin
      state        <= state_nxt;
      exec_first_q <= (state_nxt == S_EXEC) && (state != S_EXEC);
      if (state == S_DECODE) begin
        ben_q       <= ben_now;
        jsr_off11_q <= ir[11];
      end
      if (retire) icount_q <= icount_q + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH1;
      S_FETCH1: state_nxt = S_FETCH2;
      S_FETCH2: if (mem_r) state_nxt = S_FETCH3;
      S_FETCH3: state_nxt = S_DECODE;
      S_DECODE: state_nxt = dispatch(ir[15:12]);
      S_BR, S_JMP, S_JSR: begin
        retire    = 1'b1;
        state_nxt = run ? S_FETCH1 : S_IDLE;
      end
      S_EXEC: begin
        if (exec_done) begin
          retire    = 1'b1;
          state_nxt = run ? S_FETCH1 : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ldMAR      = 1'b0;
    gatePC     = 1'b0;
    ldPC       = 1'b0;
    mem_en     = 1'b0;
    ldIR       = 1'b0;
    ldR7       = 1'b0;
    exec_start = 1'b0;
    selPCMUX   = PCMUX_PC1;
    selADDR1   = ADDR1_PC;
    selADDR2   = ADDR2_ZERO;
    case (state)
      S_FETCH1: begin
        ldMAR    = 1'b1;
        gatePC   = 1'b1;
        ldPC     = 1'b1;
        selPCMUX = PCMUX_PC1;
      end
      S_FETCH2: mem_en = 1'b1;
      S_FETCH3: ldIR = 1'b1;
      S_BR: begin
        if (ben_q) begin
          ldPC     = 1'b1;
          selPCMUX = PCMUX_EAB;
          selADDR1 = ADDR1_PC;
          selADDR2 = ADDR2_OFF9;
        end
      end
      S_JMP: begin
        ldPC     = 1'b1;
        selPCMUX = PCMUX_EAB;
        selADDR1 = ADDR1_BASER;
        selADDR2 = ADDR2_ZERO;
      end
      // R7 latches the PC off the bus in the same cycle the PC is overwritten.
      S_JSR: begin
        gatePC   = 1'b1;
        ldR7     = 1'b1;
        ldPC     = 1'b1;
        selPCMUX = PCMUX_EAB;
        selADDR1 = jsr_off11_q ? ADDR1_PC : ADDR1_BASER;
        selADDR2 = jsr_off11_q ? ADDR2_OFF11 : ADDR2_ZERO;
      end
      S_EXEC: exec_start = exec_first_q;
      default: ;
    endcase
  end

  assign ldMDR     = (state == S_FETCH2) && mem_r;
  assign state_dbg = state;
  assign icount    = icount_q;

endmodule

// File: doc/lc3_pc_ctrl.md
LC3_PC_CTRL -- requirements
Module: lc3_pc_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: run  input  1  high permits starting a new fetch from IDLE/FETCH1.
REQ-004 SHALL have port: ir  input  16  current instruction register contents.
REQ-005 SHALL have port: nzp  input  3  condition codes {N,Z,P}.
REQ-006 SHALL have port: mem_r  input  1  memory read-ready handshake.
REQ-007 SHALL have port: exec_done  input  1  execute unit finished a non-control-flow instruction.
REQ-008 SHALL have outputs, 1 bit each: ldMAR, gatePC, ldPC, mem_en, ldMDR, ldIR, ldR7, exec_start.
REQ-009 SHALL have outputs: selPCMUX (2; 00 PC+1, 01 BUS, 10 EAB), selADDR1 (1; 0 PC, 1 BaseR), selADDR2 (2; 00 zero, 01 off6, 10 off9, 11 off11).
REQ-010 SHALL have outputs: state_dbg (4, current state code) and icount (16, retired-instruction count).

Function
REQ-011 SHALL implement states IDLE, FETCH1, FETCH2, FETCH3, DECODE, BR, JMP, JSR, EXEC.
REQ-012 SHALL drive all outputs except ldMDR as a function of registered state only (Moore); ldMDR = (state==FETCH2) & mem_r.
REQ-013 Outputs not asserted by the current state SHALL be 0; selPCMUX, selADDR1 and selADDR2 SHALL default to 0.
REQ-014 IDLE: go to FETCH1 when run=1, else stay.
REQ-015 FETCH1: assert ldMAR, gatePC, ldPC with selPCMUX=00 (MAR<-PC, PC<-PC+1); go to FETCH2 unconditionally.
REQ-016 FETCH2: assert mem_en; stay while mem_r=0; go to FETCH3 on mem_r=1 (no timeout).
REQ-017 FETCH3: assert ldIR; go to DECODE.
REQ-018 DECODE: register ben = (ir[11]&N)|(ir[10]&Z)|(ir[9]&P); branch on ir[15:12]: 0000->BR, 1100->JMP, 0100->JSR, all others->EXEC.
REQ-019 BR: if ben=1, assert ldPC with selPCMUX=10, selADDR1=0, selADDR2=10; if ben=0, assert nothing; go to FETCH1 if run=1, else IDLE.
REQ-020 JMP: assert ldPC with selPCMUX=10, selADDR1=1, selADDR2=00; next state as REQ-019.
REQ-021 JSR: assert gatePC, ldR7 and ldPC with selPCMUX=10 in the same cycle (R7 receives the pre-update PC); ir[11]=1 selects selADDR1=0, selADDR2=11; ir[11]=0 selects selADDR1=1, selADDR2=00; next state as REQ-019.
REQ-022 EXEC: assert exec_start for exactly the first cycle in EXEC; stay until exec_done=1, then follow REQ-019. An exec_done that arrives in the first EXEC cycle SHALL be accepted.
REQ-023 exec_done outside EXEC and mem_r outside FETCH2 SHALL be ignored.
REQ-024 icount SHALL increment by 1 on each exit from BR/JMP/JSR/EXEC and wrap from 16'hFFFF to 16'h0000.
REQ-025 Minimum latency: a control-flow instruction with mem_r=1 in its first FETCH2 cycle SHALL take 5 cycles from FETCH1 entry back to FETCH1.
REQ-026 run deasserted mid-instruction SHALL NOT abort it; it is only sampled at IDLE and at instruction end.
REQ-027 Reserved opcode 1101 SHALL be treated as EXEC.

Reset
REQ-028 rst=0 SHALL asynchronously force state=IDLE, ben=0, icount=0, and all control outputs to 0, including during FETCH2 mem waits and EXEC waits.
REQ-029 On rst release, the first transition SHALL occur on the next rising clk edge, per REQ-014.

Structure
REQ-030 State encodings, opcode constants, PCMUX/ADDR1/ADDR2 codes SHALL reside in shared package lc3_ctrl_pkg for reuse by the PC and datapath blocks.
REQ-031 The ben evaluation SHALL be a separate combinational sub-module lc3_ben (ir[11:9], nzp -> ben); everything else SHALL be in lc3_pc_ctrl.

Verification
REQ-032 Reset, then run=1, mem_r tied 1, ir=16'h0E05 (BRnzp), nzp=3'b010 -> states FETCH1,FETCH2,FETCH3,DECODE,BR; ldPC=1, selPCMUX=10, selADDR2=10 in BR; icount=1.
REQ-033 ir=16'h0805 (BRn), nzp=3'b001 -> BR cycle has ldPC=0; next state FETCH1.
REQ-034 ir=16'h4802 (JSR) -> one cycle with ldR7=gatePC=ldPC=1, selADDR2=11; ir=16'h4080 (JSRR R2) -> selADDR1=1, selADDR2=00.
REQ-035 ir=16'h1021 (ADD), exec_done held 0 for 3 cycles then 1 -> exec_start high exactly 1 cycle; EXEC lasts 4 cycles; icount increments once.
REQ-036 mem_r=0 for 5 cycles in FETCH2 -> mem_en held, ldMDR=0; mem_r=1 -> ldMDR=1 same cycle, then FETCH3.
REQ-037 Assert rst=0 mid-EXEC and mid-FETCH2 -> immediate IDLE, icount=0, all outputs 0 without waiting for clk; run=0 at BR end -> IDLE.
